// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
// Issues one instruction-memory request at a time for the PC supplied by the
// PC register, and parks each returned instruction with its PC in a one-entry
// output buffer until decode takes it. A redirect (jbr_taken_i) empties the
// buffer and throws away any response still outstanding.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   if_pc_i             current PC from the PC register
//   jbr_taken_i         redirect strobe (PC register loads target this cycle)
//   stall_o             holds the PC register when 1
//   inst_req_o          instruction-memory request valid
//   inst_addr_o         request address (always if_pc_i)
//   inst_addr_ok_i      memory accepts the request this cycle
//   inst_data_ok_i      read data valid this cycle
//   inst_rdata_i        read data
//   id_allowin_i        decode consumes the buffered instruction this cycle
//   if_valid_o          output buffer holds a valid instruction
//   if_bus_o            {pc, inst} of the buffered instruction
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_W-1:0]        if_pc_i,
    input  logic                     jbr_taken_i,
    output logic                     stall_o,
    output logic                     inst_req_o,
    output logic [ADDR_W-1:0]        inst_addr_o,
    input  logic                     inst_addr_ok_i,
    input  logic                     inst_data_ok_i,
    input  logic [INST_W-1:0]        inst_rdata_i,
    input  logic                     id_allowin_i,
    output logic                     if_valid_o,
    output logic [ADDR_W+INST_W-1:0] if_bus_o
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic              discard;
    logic [ADDR_W-1:0] req_pc;

    logic accept;
    logic load;

    always_comb begin
        // A request is only raised when the buffer can take the answer, so
        // the buffer never has to load while decode is holding it.
        inst_req_o  = !rst_i && (state == S_REQ) && !jbr_taken_i &&
                      (!if_valid_o || id_allowin_i);
        inst_addr_o = if_pc_i;
        accept      = inst_req_o && inst_addr_ok_i;
        stall_o     = rst_i || (!accept && !jbr_taken_i);
        load        = (state == S_WAIT) && inst_data_ok_i && !discard &&
                      !jbr_taken_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_REQ;
            discard    <= 1'b0;
            req_pc     <= '0;
            if_valid_o <= 1'b0;
            if_bus_o   <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) begin
                        req_pc <= if_pc_i;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Any response ends the wait; it is kept only via load.
                    // A flush with no response yet marks the eventual one
                    // for dropping.
                    if (inst_data_ok_i) begin
                        discard <= 1'b0;
                        state   <= S_REQ;
                    end else if (jbr_taken_i) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase

            // Load wins over consumption; flush wins over both.
            if (jbr_taken_i) begin
                if_valid_o <= 1'b0;
            end else if (load) begin
                if_valid_o <= 1'b1;
                if_bus_o   <= {req_pc, inst_rdata_i};
            end else if (if_valid_o && id_allowin_i) begin
                if_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter ADDR_W, default 32: width of PC and instruction address.
REQ-002 Parameter INST_W, default 32: width of instruction word.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 if_pc_i  input  ADDR_W  current PC from the PC register.
REQ-006 jbr_taken_i  input  1  redirect strobe, same cycle the PC register loads the jump target; flushes fetch.
REQ-007 stall_o  output  1  holds the PC register when 1.
REQ-008 inst_req_o  output  1  instruction-memory request valid.
REQ-009 inst_addr_o  output  ADDR_W  request address.
REQ-010 inst_addr_ok_i  input  1  memory accepts the request this cycle.
REQ-011 inst_data_ok_i  input  1  read data valid this cycle, in order, at most one outstanding.
REQ-012 inst_rdata_i  input  INST_W  read data.
REQ-013 id_allowin_i  input  1  decode consumes the output this cycle if valid.
REQ-014 if_valid_o  output  1  output buffer holds a valid instruction.
REQ-015 if_bus_o  output  ADDR_W+INST_W  {pc, inst}, stable while if_valid_o=1 and not consumed.

Function
REQ-016 FSM states: REQ (may issue), WAIT (one request outstanding).
REQ-017 inst_req_o=1 only in REQ, when jbr_taken_i=0 and (if_valid_o=0 or id_allowin_i=1); inst_addr_o=if_pc_i combinationally.
REQ-018 Handshake: request accepted when inst_req_o & inst_addr_ok_i; then latch req_pc<=if_pc_i and go to WAIT.
REQ-019 Once asserted, inst_req_o and inst_addr_o stay stable until accepted, unless jbr_taken_i deasserts the request.
REQ-020 stall_o = !(request accepted) & !jbr_taken_i; the PC advances by 4 only on acceptance and loads the target on redirect.
REQ-021 WAIT with inst_data_ok_i=1, discard=0, jbr_taken_i=0: buffer <= {req_pc, inst_rdata_i}, if_valid_o<=1 next cycle; go to REQ.
REQ-022 Latency: acceptance at cycle N, data_ok earliest N+1, if_valid_o earliest N+2.
REQ-023 Buffer clears (if_valid_o<=0) when if_valid_o & id_allowin_i and nothing is loaded the same cycle; load takes priority over clear.
REQ-024 Buffer never loads while if_valid_o=1 and id_allowin_i=0; REQ-017 guarantees this.
REQ-025 Flush (jbr_taken_i=1): if_valid_o<=0 next cycle; no request issued that cycle.
REQ-026 Flush in WAIT without same-cycle data_ok: set discard<=1 and stay in WAIT.
REQ-027 Flush in WAIT with same-cycle data_ok: drop the response; discard stays 0; go to REQ.
REQ-028 WAIT with discard=1 and data_ok: drop the response, clear discard, go to REQ; a new flush in that cycle keeps the drop and leaves discard=0.
REQ-029 Flush in REQ: stay in REQ; discard unchanged (0).
REQ-030 At most one request outstanding; no request issued in WAIT.

Reset
REQ-031 rst_i=1 forces state=REQ, discard=0, if_valid_o=0, if_bus_o=0, req_pc=0 on the next edge.
REQ-032 During reset, inst_req_o=0 and stall_o=1.
REQ-033 Reset mid-WAIT abandons the outstanding request; memory shares rst_i, so no stale data_ok arrives after reset.
REQ-034 First request is issued the cycle after rst_i deasserts, using the current if_pc_i.

Verification
REQ-035 Zero-wait memory (addr_ok=1, data_ok the next cycle), id_allowin=1, pc 0x1C000000 -> pc/inst pairs 0x1C000000, 0x1C000004, ... with if_valid_o every other cycle.
REQ-036 id_allowin=0 with buffer full -> inst_req_o=0, stall_o=1, if_bus_o unchanged; on release, consumed and the next request is issued the same cycle.
REQ-037 Flush in WAIT, data_ok 3 cycles later -> that data dropped (if_valid_o stays 0); the next request uses the target 0x1C000100.
REQ-038 Flush coincident with data_ok -> response dropped, discard=0; the next request is at the target.
REQ-039 addr_ok held low 4 cycles -> inst_addr_o stable, stall_o=1 throughout; acceptance on cycle 5 advances the PC once.
REQ-040 rst_i asserted in WAIT -> next cycle if_valid_o=0 and state REQ; first post-reset request addr = if_pc_i.
